seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
Time-multiplexed scan controller for an 8-digit, common-anode seven-segment display. It sits directly upstream of the seven-segment decoder. It holds a 32-bit display word and walks through the digits, driving one active-low anode at a time. For the selected digit it presents the 4-bit nibble and the 2-bit decimal-point code that the decoder consumes. Display updates are double-buffered and take effect only at frame boundaries, so no partial or torn frame is ever shown.

Parameters:
CLK_DIV, 16'd50000, clk cycles per digit slot; legal range 2..65535; the bench uses 4.
LZB_DEFAULT, 1'b0, reset value of the leading-zero blanking enable.

Ports:
clk  input  1  system clock; every register updates on the rising edge.
resetn  input  1  synchronous reset, active-low.
en  input  1  scan enable.
load  input  1  one-cycle strobe that captures data_in, dp_in and lzb_in.
data_in  input  32  display word; nibble i drives digit i, digit 0 is the rightmost.
dp_in  input  8  bit i=1 lights the decimal point of digit i.
lzb_in  input  1  leading-zero blanking enable.
an  output  8  anode selects, active-low, one-hot-low while displaying.
nibble  output  4  value for the decoder's data input.
q  output  2  decimal-point code for the decoder: 2'b10 = dp on, 2'b00 = dp off.
frame_start  output  1  one-cycle pulse when digit 0 becomes active.

Behaviour:
- Reset (resetn=0 sampled at a clk edge):
  - div_cnt=0, idx=0.
  - shadow={32'h0, 8'h00, LZB_DEFAULT}, pending=0, pend_v=0.
  - an=8'hFF, nibble=0, q=2'b00, frame_start=0.
  - Reset asserted mid-frame aborts the frame immediately and discards any pending data.
- Divider:
  - When en=1, div_cnt increments each cycle. At CLK_DIV-1 it wraps to 0 and asserts an internal tick.
  - When en=0, div_cnt and idx hold.
- Digit index:
  - On tick, idx advances 0→1→…→7→0.
  - The tick that moves idx from 7 to 0 is the frame boundary.
- Load path:
  - load=1 writes {data_in, dp_in, lzb_in} into pending and sets pend_v=1.
  - A load while pend_v=1 overwrites pending; the last load wins.
  - At the frame boundary with pend_v=1, shadow←pending and pend_v←0.
  - If load and the frame boundary coincide, shadow takes the inputs directly and pend_v←0. The new word is visible in the same frame that starts.
  - load is accepted regardless of en.
- Output stage, registered, one cycle after idx or shadow changes:
  - nibble = shadow.data[4*idx+3 : 4*idx].
  - q = 2'b10 if shadow.dp[idx] is 1, otherwise 2'b00.
  - an = ~(8'b1 << idx), unless the digit is blanked.
  - Blanked digit: an=8'hFF for that slot; nibble and q still follow the rules above.
  - A digit is blanked when lzb=1, idx≠0, shadow.dp[idx]=0, and every nibble from idx up to 7 is 4'h0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - en=0 forces an=8'hFF on the next cycle; nibble and q hold.
- frame_start:
  - Registered. It is 1 in exactly the cycle the outputs first present idx=0 after a frame boundary.
  - It is also 1 on the first cycle in which en=1 after reset.
- Timing relations:
  - Each digit is lit for exactly CLK_DIV cycles.
  - A full frame is 8*CLK_DIV cycles.
  - Latency from load to a visible change is at most 8*CLK_DIV+1 cycles.
- Ignored conditions: en toggling mid-slot resumes the count where it stopped. No overflow condition exists; all counters wrap.

Test Plan:
1. Reset and scan: CLK_DIV=4, reset, en=1, load 32'h8765_4321 with dp=0.
   → After the next frame boundary, an steps FE, FD, FB, … 7F, each for 4 cycles. nibble steps 1, 2, … 8. q=00 throughout.
2. Decimal point: load dp_in=8'h04.
   → q=2'b10 only while an=8'hFB; q=2'b00 on all other slots.
3. Leading-zero blanking: lzb_in=1, data=32'h0000_00A0.
   → an=FF in slots 2–7; digits 0 and 1 lit showing 0 and A.
   → With data=0, only digit 0 is lit.
4. Double buffering: load 32'h1111_1111 mid-frame, then 32'h2222_2222 two cycles later.
   → The current frame stays unchanged; the next frame shows only 2s.
   → load on the boundary cycle itself: the new value appears at idx 0 immediately.
5. Enable: en=0 mid-slot for 10 cycles.
   → an=FF one cycle later and idx holds. On re-enable, the same digit resumes with the remaining slot count.
6. Reset mid-frame with pend_v=1: resetn=0 for one cycle.
   → All outputs return to reset values; shadow=0 and pending is discarded.

Source files
------------

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 8-digit common-anode seven-segment scan controller with frame-synchronous double buffering
//   clk, resetn      : clock, synchronous active-low reset
//   en               : scan enable (divider and digit index hold while low, anodes go dark)
//   load             : strobe capturing data_in/dp_in/lzb_in into the pending buffer
//   data_in, dp_in   : display word (nibble i -> digit i, digit 0 rightmost) and per-digit decimal points
//   lzb_in           : leading-zero blanking enable
//   an               : active-low anode selects
//   nibble, q        : selected digit value and decimal-point code (2'b10 = on) for the decoder
//   frame_start      : pulse while digit 0 is first presented in a frame
module seg_scan_mux #(
  parameter logic [15:0] CLK_DIV     = 16'd50000,
  parameter logic        LZB_DEFAULT = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        lzb_in,
  output logic [7:0]  an,
  output logic [3:0]  nibble,
  output logic [1:0]  q,
  output logic        frame_start
);
  logic [15:0] div_cnt;
  logic [2:0]  idx;
  logic [31:0] sh_data, pend_data;
  logic [7:0]  sh_dp, pend_dp;
  logic        sh_lzb, pend_lzb, pend_v;
  logic        started, wrap;
  logic        tick, boundary, blank;
  assign tick     = en && (div_cnt == CLK_DIV - 16'd1);
  assign boundary = tick && (idx == 3'd7);
  // blank when this digit and everything to its left is zero and it carries no dp
  assign blank = sh_lzb && (idx != 3'd0) && !sh_dp[idx] && ((sh_data >> {idx, 2'b00}) == 32'h0);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt     <= '0;
      idx         <= '0;
      sh_data     <= '0;
      sh_dp       <= '0;
      sh_lzb      <= LZB_DEFAULT;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_lzb    <= 1'b0;
      pend_v      <= 1'b0;
      started     <= 1'b0;
      wrap        <= 1'b0;
      an          <= 8'hFF;
      nibble      <= '0;
      q           <= 2'b00;
      frame_start <= 1'b0;
    end else begin
      if (en) begin
        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
        idx     <= tick ? idx + 3'd1 : idx;
      end
      if (boundary) begin
        // a load landing on the boundary bypasses pending so the new frame shows it
        if (load) {sh_data, sh_dp, sh_lzb} <= {data_in, dp_in, lzb_in};
        else if (pend_v) {sh_data, sh_dp, sh_lzb} <= {pend_data, pend_dp, pend_lzb};
        pend_v <= 1'b0;
      end else if (load) begin
        {pend_data, pend_dp, pend_lzb} <= {data_in, dp_in, lzb_in};
        pend_v <= 1'b1;
      end
      // wrap remembers a boundary until the idx=0 outputs are actually presented
      wrap        <= boundary ? 1'b1 : (en ? 1'b0 : wrap);
      started     <= started | en;
      frame_start <= en && (wrap || !started);
      an          <= (!en || blank) ? 8'hFF : ~(8'b1 << idx);
      if (en) begin
        nibble <= sh_data[{idx, 2'b00} +: 4];
        q      <= sh_dp[idx] ? 2'b10 : 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: randomized and directed checks of seg_scan_mux against a frame-position model
module tb_seg_scan_mux;
  localparam int DIV = 4;
  localparam int FRAME = 8 * DIV;
  logic        clk, resetn, en, load, lzb_in, frame_start;
  logic [31:0] data_in;
  logic [7:0]  dp_in, an;
  logic [3:0]  nibble;
  logic [1:0]  q;
  int checks = 0, errors = 0;
  seg_scan_mux #(.CLK_DIV(16'd4), .LZB_DEFAULT(1'b0)) dut (
    .clk(clk), .resetn(resetn), .en(en), .load(load), .data_in(data_in), .dp_in(dp_in),
    .lzb_in(lzb_in), .an(an), .nibble(nibble), .q(q), .frame_start(frame_start)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // model: position within the frame counted in enabled cycles, plus shown/pending buffers
  int          ecnt, d;
  logic [31:0] m_sd, m_pd;
  logic [7:0]  m_sdp, m_pdp;
  logic        m_slz, m_plz, m_pv, model_ok = 0;
  logic [7:0]  e_an;
  logic [3:0]  e_nib;
  logic [1:0]  e_q;
  logic        e_fs;
  function automatic logic [7:0] an_of(int k);
    return ~(8'b1 << k);
  endfunction
  function automatic logic blanked(int k);
    if (!m_slz || k == 0 || m_sdp[k]) return 1'b0;
    for (int j = k; j < 8; j++) if (m_sd[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    if (!resetn) begin
      ecnt = 0; m_sd = 0; m_sdp = 0; m_slz = 0; m_pv = 0;
      e_an = 8'hFF; e_nib = 0; e_q = 0; e_fs = 0; model_ok = 1;
    end else begin
      d = ecnt / DIV;
      e_fs = en && ecnt == 0;
      if (en) begin
        e_an  = blanked(d) ? 8'hFF : an_of(d);
        e_nib = m_sd[4*d +: 4];
        e_q   = m_sdp[d] ? 2'b10 : 2'b00;
      end else e_an = 8'hFF;
      if (en && ecnt == FRAME - 1) begin
        if (load) begin m_sd = data_in; m_sdp = dp_in; m_slz = lzb_in; end
        else if (m_pv) begin m_sd = m_pd; m_sdp = m_pdp; m_slz = m_plz; end
        m_pv = 0;
      end else if (load) begin
        m_pd = data_in; m_pdp = dp_in; m_plz = lzb_in; m_pv = 1;
      end
      if (en) ecnt = (ecnt + 1) % FRAME;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (model_ok) begin
    chk("model_an", an, e_an);
    chk("model_nibble", nibble, e_nib);
    chk("model_q", q, e_q);
    chk("model_fs", frame_start, e_fs);
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ld(input logic [31:0] dv, input logic [7:0] pv, input logic zv);
    data_in = dv; dp_in = pv; lzb_in = zv; load = 1;
    step(1);
    load = 0;
  endtask
  task automatic wait_fs;
    int n = 0;
    while (!frame_start && n < 200) begin step(1); n++; end
    chk("fs_wait", frame_start, 1);
  endtask
  task automatic next_frame;
    step(1);
    wait_fs();
  endtask
  initial begin
    resetn = 0; en = 0; load = 0; data_in = 0; dp_in = 0; lzb_in = 0;
    step(2);
    chk("rst_an", an, 8'hFF); chk("rst_nibble", nibble, 0); chk("rst_q", q, 0); chk("rst_fs", frame_start, 0);
    resetn = 1;
    ld(32'h8765_4321, 8'h00, 0);
    en = 1;
    step(2);
    wait_fs();
    for (int i = 0; i < FRAME; i++) begin
      chk("scan_an", an, an_of(i / DIV)); chk("scan_nibble", nibble, i / DIV + 1); chk("scan_q", q, 0);
      step(1);
    end
    ld(32'h8765_4321, 8'h04, 0);
    next_frame();
    for (int i = 0; i < FRAME; i++) begin chk("dp_q", q, (i / DIV == 2) ? 2 : 0); step(1); end
    ld(32'h0000_00A0, 8'h00, 1);
    next_frame();
    for (int i = 0; i < FRAME; i++) begin
      chk("lzb_an", an, (i / DIV < 2) ? an_of(i / DIV) : 8'hFF);
      chk("lzb_nibble", nibble, (i / DIV == 1) ? 4'hA : 4'h0);
      step(1);
    end
    ld(32'h0, 8'h00, 1);
    next_frame();
    for (int i = 0; i < FRAME; i++) begin chk("zero_an", an, (i < DIV) ? 8'hFE : 8'hFF); step(1); end
    step(5);
    ld(32'h1111_1111, 8'h00, 0);
    step(1);
    ld(32'h2222_2222, 8'h00, 0);
    chk("dbuf_hold", nibble, 0);
    next_frame();
    for (int i = 0; i < FRAME; i++) begin chk("dbuf_new", nibble, 2); step(1); end
    step(30);
    data_in = 32'h3333_3333; dp_in = 0; lzb_in = 0; load = 1;
    step(1);
    load = 0;
    chk("bnd_old", nibble, 2);
    step(1);
    chk("bnd_fs", frame_start, 1); chk("bnd_nibble", nibble, 3); chk("bnd_an", an, 8'hFE);
    step(5);
    en = 0;
    step(1);
    chk("en_off_an", an, 8'hFF); chk("en_off_nibble", nibble, 3);
    step(9);
    en = 1;
    step(1); chk("resume_an0", an, 8'hFD);
    step(1); chk("resume_an1", an, 8'hFD);
    step(1); chk("resume_an2", an, 8'hFB);
    ld(32'h4444_4444, 8'hFF, 0);
    resetn = 0;
    step(1);
    resetn = 1;
    chk("mrst_an", an, 8'hFF); chk("mrst_nibble", nibble, 0); chk("mrst_q", q, 0); chk("mrst_fs", frame_start, 0);
    step(1);
    chk("mrst_fs1", frame_start, 1); chk("mrst_an1", an, 8'hFE);
    step(40);
    chk("mrst_discard", nibble, 0);
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 10) != 0;
      load = ($urandom % 20) == 0;
      data_in = $urandom >> ($urandom % 32);
      dp_in = ($urandom % 4 == 0) ? 8'($urandom) : 8'h00;
      lzb_in = $urandom % 2;
      resetn = ($urandom % 500) != 0;
      step(1);
    end
    resetn = 1; load = 0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
